instruction_fetch_unit: RTL and testbench

//  Fetch initiator for the word-addressed, combinational-read instruction memory.

---
 rtl/instruction_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch initiator for a word-addressed instruction memory with combinational
//   read. It holds the PC, presents it as the memory address and registers the
//   returned word together with its PC into a single output slot. Decode takes
//   the slot with a valid/ready handshake. A taken branch or jump loads a new PC
//   through redirect_valid/redirect_pc. The unit halts on a misaligned PC or an
//   out-of-range PC, and only reset leaves the halted state.
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   imem_addr       byte address presented to instruction memory (= PC)
//   imem_instr      memory read data, valid in the same cycle as imem_addr
//   redirect_valid  load a new PC (branch/jump taken)
//   redirect_pc     redirect target byte address
//   if_valid        output slot holds an instruction
//   if_instr        instruction in the output slot
//   if_pc           byte address of if_instr
//   if_ready        decode accepts the slot this cycle
//   fetch_error     sticky halt indication
//   fetch_count     number of completed handshakes, wraps at 2^32
module instruction_fetch_unit #(
  parameter int                        DATA_WIDTH    = 32,
  parameter int                        ADDRESS_WIDTH = 32,
  parameter int                        MEM_SIZE      = 256,
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     if_valid,
  output logic [DATA_WIDTH-1:0]    if_instr,
  output logic [ADDRESS_WIDTH-1:0] if_pc,
  input  logic                     if_ready,
  output logic                     fetch_error,
  output logic [31:0]              fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [ADDRESS_WIDTH-3:0] MEM_WORDS = (ADDRESS_WIDTH-2)'(MEM_SIZE);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP   = ADDRESS_WIDTH'(4);

  state_t                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   pc_q, pc_d;
  logic                       if_valid_q, if_valid_d;
  logic [DATA_WIDTH-1:0]      if_instr_q, if_instr_d;
  logic [ADDRESS_WIDTH-1:0]   if_pc_q, if_pc_d;
  logic [31:0]                fetch_count_q, fetch_count_d;

  logic take;
  logic slot_free;
  logic pc_ok;
  logic redirect_bad;

  // Handshake and PC legality terms shared by the next-state and datapath logic.
  // The slot can accept a new word when it is empty or is being drained now.
  always_comb begin
    take         = if_valid_q & if_ready;
    slot_free    = ~if_valid_q | take;
    pc_ok        = (pc_q[1:0] == 2'b00) && (pc_q[ADDRESS_WIDTH-1:2] < MEM_WORDS);
    redirect_bad = (redirect_pc[1:0] != 2'b00);
  end

  // State register plus all datapath flops; reset drops the slot and restarts at RESET_PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next state: halt on a misaligned redirect target, or when a load is due
  // but the PC is illegal. HALT is absorbing until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          if (redirect_bad) state_d = HALT;
        end else if (slot_free && !pc_ok) begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Datapath update. Redirect wins over a load: the word read this cycle is
  // thrown away and the slot is emptied, while a concurrent take still counts.
  // The PC still takes a misaligned redirect target so it is visible for debug.
  always_comb begin
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    fetch_count_d = fetch_count_q;

    if (take) begin
      fetch_count_d = fetch_count_q + 32'd1;
      if_valid_d    = 1'b0;
    end

    if (state_q == RUN) begin
      if (redirect_valid) begin
        if_valid_d = 1'b0;
        pc_d       = redirect_pc;
      end else if (slot_free && pc_ok) begin
        if_instr_d = imem_instr;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
        pc_d       = pc_q + PC_STEP;
      end
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    imem_addr   = pc_q;
    if_valid    = if_valid_q;
    if_instr    = if_instr_q;
    if_pc       = if_pc_q;
    fetch_error = (state_q == HALT);
    fetch_count = fetch_count_q;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Self-checking bench for instruction_fetch_unit. A behavioural model of the
//   fetch unit (PC, one-entry slot, halt flag, handshake counter) is advanced
//   once per clock and every DUT output is compared against it after each edge.
//   Directed sequences cover the reference scenarios, then randomized ready,
//   redirect and reset traffic runs against the same model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        fetch_error;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_slot_pc;
  logic        m_halt;
  logic [31:0] m_count;

  instruction_fetch_unit #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .MEM_SIZE      (256),
    .RESET_PC      (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .fetch_error    (fetch_error),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory indexed by addr[9:2]
  assign imem_instr = mem[imem_addr[9:2]];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the reference behaviour, using the inputs held across the edge.
  task automatic modelEdge();
    logic taken;
    if (!rst_n) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_slot_pc = 32'h0;
      m_halt = 1'b0; m_count = 32'h0;
    end else begin
      taken = m_valid && if_ready;
      if (taken) begin
        m_count = m_count + 1;
        m_valid = 1'b0;
      end
      if (!m_halt) begin
        if (redirect_valid) begin
          m_valid = 1'b0;
          m_pc    = redirect_pc;
          if (redirect_pc % 4 != 0) m_halt = 1'b1;
        end else if (m_valid == 1'b0) begin
          if (m_pc % 4 == 0 && m_pc / 4 < 256) begin
            m_instr   = mem[m_pc / 4];
            m_slot_pc = m_pc;
            m_valid   = 1'b1;
            m_pc      = m_pc + 4;
          end else begin
            m_halt = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("imem_addr",   imem_addr,           m_pc);
    checkOutput("if_valid",    {31'b0, if_valid},   {31'b0, m_valid});
    checkOutput("if_instr",    if_instr,            m_instr);
    checkOutput("if_pc",       if_pc,               m_slot_pc);
    checkOutput("fetch_error", {31'b0, fetch_error}, {31'b0, m_halt});
    checkOutput("fetch_count", fetch_count,         m_count);
  endtask

  // Drive inputs away from the edge, clock once, advance the model, then compare.
  task automatic applyStimulus(input logic rst_in, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst_n          = rst_in;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    #2;

    // Reset state
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("reset_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("reset_count", fetch_count, 32'h0);

    // Streaming with ready held high
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      if (k <= 8) begin
        checkOutput("stream_pc",    if_pc,    32'(4 * (k - 1)));
        checkOutput("stream_instr", if_instr, 32'h1000 + 32'(k - 1));
      end
    end
    checkOutput("stream_count", fetch_count, 32'd8);

    // Stall on pc=8 then resume at 0xC
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("stall_start_pc", if_pc, 32'h8);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("stall_pc",    if_pc,    32'h8);
      checkOutput("stall_instr", if_instr, 32'h1002);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("resume_pc", if_pc, 32'hC);

    // Redirect to 0x40 while slot holds 0x10
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("pre_redirect_pc", if_pc, 32'h10);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0);
    checkOutput("redirect_flush", {31'b0, if_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("redirect_pc",    if_pc,    32'h40);
    checkOutput("redirect_instr", if_instr, 32'h1010);

    // Misaligned redirect halts; further redirects are ignored
    applyStimulus(1'b1, 1'b1, 32'h42, 1'b1);
    checkOutput("misalign_error", {31'b0, fetch_error}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 32'h0, 1'b1);
      checkOutput("halt_valid", {31'b0, if_valid}, 32'h0);
      checkOutput("halt_addr",  imem_addr, 32'h42);
    end

    // Sequential run off the end of memory
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 256; k++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("end_last_pc", if_pc, 32'h3FC);
    checkOutput("end_no_error", {31'b0, fetch_error}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("end_error", {31'b0, fetch_error}, 32'h1);
    checkOutput("end_valid", {31'b0, if_valid}, 32'h0);

    // Reset mid-stream at pc=0x20
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("midreset_pre_pc", if_pc, 32'h20);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("midreset_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("midreset_pc",    if_pc,     32'h0);
    checkOutput("midreset_addr",  imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("refetch_pc", if_pc, 32'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic        r_rst;
      logic        r_rv;
      logic [31:0] r_pc;
      logic        r_rdy;
      r_rst = ($urandom_range(0, 99) >= 2);
      r_rv  = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 9))
        0:       r_pc = $urandom;
        1:       r_pc = 32'($urandom_range(250, 300)) * 4;
        default: r_pc = 32'($urandom_range(0, 255)) * 4;
      endcase
      r_rdy = ($urandom_range(0, 99) < 70);
      applyStimulus(r_rst, r_rv, r_pc, r_rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
